// File: rtl/button_encoder_pkg.sv
// button_encoder_pkg: shared code constants, FSM state encoding and pattern decoder.
package button_encoder_pkg;

    localparam logic [6:0] CODE_ALL  = 7'd6;
    localparam logic [6:0] CODE_NONE = 7'd127;

    typedef enum logic {IDLE, HELD} state_t;

    // One-hot maps btn[5]..btn[0] to codes 0..5; everything non-legal decodes to CODE_NONE.
    function automatic logic [6:0] decode(input logic [5:0] d);
        logic [6:0] c;
        c = CODE_NONE;
        for (int i = 0; i < 6; i++)
            if (d == 6'(1 << i)) c = 7'(5 - i);
        if (d == 6'h3f) c = CODE_ALL;
        return c;
    endfunction

endpackage

// File: rtl/debounce6.sv
// debounce6: two-flop synchronizer plus stability counter for a 6-bit button bus.
module debounce6 #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] raw,
    output logic [5:0] deb
);
    localparam int W = $clog2(DEB_CYCLES);
    localparam logic [W-1:0] CNT_MAX = W'(DEB_CYCLES - 1);

    logic [5:0]   r_s1, r_s2, r_cand, r_deb;
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_cand <= '0;
            r_cnt  <= '0;
            r_deb  <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Decision uses the pre-edge count, so deb follows cand one cycle after saturation.
            if (r_cnt == CNT_MAX) r_deb <= r_cand;
        end
    end

    assign deb = r_deb;

endmodule

// File: rtl/button_encoder.sv
// button_encoder: debounced 6-button encoder reporting one event per full press/release.
module button_encoder
    import button_encoder_pkg::*;
#(
    parameter int DEB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn,
    output logic [6:0] n,
    output logic       valid,
    output logic       err,
    output logic       held
);
    logic [5:0] w_deb;
    logic [6:0] w_code, w_n;
    logic       w_press, w_valid, w_err;
    state_t     r_state, w_next;

    debounce6 #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn),
        .deb  (w_deb)
    );

    always_comb begin
        w_code  = decode(w_deb);
        w_press = (r_state == IDLE) && |w_deb;
        w_next  = w_press ? HELD : ((r_state == HELD) && ~|w_deb) ? IDLE : r_state;
        w_n     = w_press ? w_code : n;
        w_valid = w_press && (w_code != CODE_NONE);
        w_err   = w_press && (w_code == CODE_NONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            n       <= CODE_NONE;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_next;
            n       <= w_n;
            valid   <= w_valid;
            err     <= w_err;
        end
    end

    assign held = (r_state == HELD);

endmodule

// File: tb/tb_button_encoder.sv
// tb_button_encoder: directed scenarios plus random presses against a stable-window reference model.
module tb_button_encoder;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] btn = '0;
    logic [6:0] n;
    logic       valid, err, held;

    int checks = 0, errors = 0;
    int nvalid = 0, nerr = 0;

    button_encoder #(.DEB_CYCLES(DEB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .n    (n),
        .valid(valid),
        .err  (err),
        .held (held)
    );

    always #5 clk = ~clk;

    // Reference: a pattern is accepted once it was sampled on DEB consecutive edges,
    // seen through the 2-flop synchronizer and candidate stage (3 edges of delay).
    logic [5:0] hist[$];
    logic [5:0] m_deb;
    logic [6:0] m_n;
    logic       m_valid, m_err, m_held;

    function automatic logic [6:0] ref_code(input logic [5:0] p);
        if (p == 6'h3f) return 7'd6;
        if ($countones(p) == 1)
            for (int b = 0; b < 6; b++) if (p[b]) return 7'(5 - b);
        return 7'd127;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = {};
            for (int i = 0; i < DEB + 3; i++) hist.push_back(6'd0);
            m_deb = '0; m_n = 7'd127; m_valid = 0; m_err = 0; m_held = 0;
        end else begin
            int  last;
            bit  same;
            m_valid = 0;
            m_err   = 0;
            if (!m_held && m_deb != 0) begin
                m_held  = 1;
                m_n     = ref_code(m_deb);
                m_valid = (m_n != 7'd127);
                m_err   = (m_n == 7'd127);
            end else if (m_held && m_deb == 0) begin
                m_held = 0;
            end
            hist.push_back(btn);
            last = hist.size() - 1;
            same = 1;
            for (int i = 1; i < DEB; i++) if (hist[last-3-i] != hist[last-3]) same = 0;
            if (same) m_deb = hist[last-3];
            if (hist.size() > 32) void'(hist.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("n", 32'(n), 32'(m_n));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("err", 32'(err), 32'(m_err));
        chk("held", 32'(held), 32'(m_held));
        chk("excl", 32'(valid & err), 32'd0);
        if (valid) nvalid++;
        if (err) nerr++;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_n", 32'(n), 32'd127);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        steps(3);

        // Single press with exact latency
        btn = 6'b001000; nvalid = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 7) chk("lat_early", 32'(valid), 32'd0);
            if (i == 8) begin
                chk("lat_valid", 32'(valid), 32'd1);
                chk("lat_n", 32'(n), 32'd2);
            end
        end
        chk("press_count", 32'(nvalid), 32'd1);
        chk("press_held", 32'(held), 32'd1);
        btn = '0;
        steps(12);
        chk("rel_held", 32'(held), 32'd0);
        chk("rel_n", 32'(n), 32'd2);

        // Bounce shorter than the debounce window
        nvalid = 0; nerr = 0;
        for (int i = 0; i < 10; i++) begin
            btn = ((i / 2) % 2 == 0) ? 6'b000001 : 6'b000000;
            step();
        end
        btn = '0;
        steps(12);
        chk("bounce_valid", 32'(nvalid), 32'd0);
        chk("bounce_err", 32'(nerr), 32'd0);
        chk("bounce_n", 32'(n), 32'd2);

        // All buttons, then illegal pattern
        nvalid = 0;
        btn = 6'b111111;
        steps(15);
        chk("all_count", 32'(nvalid), 32'd1);
        chk("all_n", 32'(n), 32'd6);
        btn = '0;
        steps(12);
        nvalid = 0; nerr = 0;
        btn = 6'b100001;
        steps(15);
        chk("ill_err", 32'(nerr), 32'd1);
        chk("ill_valid", 32'(nvalid), 32'd0);
        chk("ill_n", 32'(n), 32'd127);
        btn = '0;
        steps(12);

        // Change while held
        nvalid = 0; nerr = 0;
        btn = 6'b100000;
        steps(12);
        btn = 6'b000010;
        steps(15);
        chk("chg_valid", 32'(nvalid), 32'd1);
        chk("chg_err", 32'(nerr), 32'd0);
        chk("chg_n", 32'(n), 32'd0);
        btn = '0;
        steps(12);

        // Re-press, then reset during the second hold
        nvalid = 0;
        btn = 6'b010000;
        steps(12);
        btn = '0;
        steps(12);
        btn = 6'b010000;
        steps(12);
        chk("repress_count", 32'(nvalid), 32'd2);
        chk("repress_n", 32'(n), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_n", 32'(n), 32'd127);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_held", 32'(held), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        steps(15);
        chk("postrst_count", 32'(nvalid), 32'd1);
        chk("postrst_n", 32'(n), 32'd1);
        btn = '0;
        steps(12);

        // Random presses, bounces and releases
        for (int r = 0; r < 60; r++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            btn = (kind == 0) ? 6'd0 :
                  (kind == 1) ? 6'(1 << $urandom_range(0, 5)) :
                  (kind == 2) ? 6'h3f : 6'($urandom);
            steps(int'($urandom_range(1, 12)));
        end
        btn = '0;
        steps(12);
        chk("final_held", 32'(held), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
